gf_digit_mult_seq: RTL

//  Sequential digit-serial multiplier/reducer for GF(2^m) and integer arithmetic, runtime-selectable field grade m.

---
 rtl/gf_digit_mult_seq.sv | 213 +++++++++++++++++++++
 1 files changed

// File: rtl/gf_digit_mult_seq.sv
// gf_digit_mult_seq
//   Digit-serial multiplier/reducer for GF(2^m) and integer operands, with a
//   runtime-selectable field grade m. MUL consumes DIGIT bits of b per cycle,
//   LSB first. RED then clears DIGIT bit positions per cycle, from 2m-1 down to m.
//
//   Operation select (mode):
//     00  carry-less multiply
//     01  integer multiply
//     10  GF(2^m) multiply, then reduce
//     11  reduce reduc_in only
//
//   Ports:
//     clk, rst_n               rising-edge clock, asynchronous active-low reset
//     in_valid / in_ready      request handshake; in_ready is high only in IDLE
//     mode                     operation select (see above)
//     polyn_grade              field grade m; modes 10/11 require 2..DATA_WIDTH
//     polyn_red_in             reduction polynomial; bit m is the leading term
//     reduc_in                 2W-bit operand for mode 11
//     a, b                     multiplier operands
//     out_valid / out_ready    result handshake; res and err hold while stalled
//     res                      2W-bit result; modes 10/11 use only res[m-1:0]
//     err                      illegal grade; meaningful only with out_valid
//     busy                     high whenever the block is not in IDLE
module gf_digit_mult_seq #(
  parameter int DATA_WIDTH = 32,
  parameter int DIGIT      = 4
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [1:0]                  mode,
  input  logic [$clog2(DATA_WIDTH):0] polyn_grade,
  input  logic [DATA_WIDTH:0]         polyn_red_in,
  input  logic [2*DATA_WIDTH-1:0]     reduc_in,
  input  logic [DATA_WIDTH-1:0]       a,
  input  logic [DATA_WIDTH-1:0]       b,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [2*DATA_WIDTH-1:0]     res,
  output logic                        err,
  output logic                        busy
);

  localparam int W    = DATA_WIDTH;
  localparam int GW   = $clog2(W) + 1;
  localparam int JW   = $clog2(2 * W) + 1;
  localparam int NDIG = W / DIGIT;
  localparam int CW   = $clog2(NDIG + 1);
  localparam logic [CW-1:0]    MUL_LAST = CW'(NDIG - 1);
  localparam logic [2*W-1:0]   ONE_2W   = 1;

  if ((DIGIT < 1) || (DIGIT > W) || ((W % DIGIT) != 0)) begin : g_bad_digit
    $error("gf_digit_mult_seq: DIGIT must lie in 1..DATA_WIDTH and divide DATA_WIDTH");
  end

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_RED, S_DONE} state_t;

  state_t          state, state_nxt;
  logic [1:0]      mode_r;
  logic [GW-1:0]   m_r;
  logic [W:0]      poly_r;
  logic [2*W-1:0]  a_sh;
  logic [W-1:0]    b_sh;
  logic [2*W-1:0]  acc;
  logic [CW-1:0]   cnt;
  logic [JW-1:0]   jpos;
  logic            err_r;

  logic            illegal_in;
  logic            mul_last;
  logic            red_last;
  logic [DIGIT-1:0] digit;
  logic [2*W-1:0]  pp_cl;
  logic [2*W-1:0]  pp_int;
  logic [2*W-1:0]  mul_acc;
  logic [2*W-1:0]  red_acc;
  logic [2*W-1:0]  poly_ext;
  int              red_j;

  // Low-n-bit masks at the three operand widths in use.
  function automatic logic [W-1:0] mask_w(input int n);
    logic [W-1:0] r;
    for (int i = 0; i < W; i++) r[i] = (i < n);
    return r;
  endfunction

  function automatic logic [W:0] mask_p(input int n);
    logic [W:0] r;
    for (int i = 0; i <= W; i++) r[i] = (i < n);
    return r;
  endfunction

  function automatic logic [2*W-1:0] mask_2w(input int n);
    logic [2*W-1:0] r;
    for (int i = 0; i < 2 * W; i++) r[i] = (i < n);
    return r;
  endfunction

  assign illegal_in = mode[1] && ((int'(polyn_grade) < 2) || (int'(polyn_grade) > W));
  assign mul_last   = (cnt == MUL_LAST);
  // jpos is the highest position still to clear. This RED cycle is the last
  // one when its DIGIT-wide window reaches down to position m.
  assign red_last   = (int'(jpos) < (int'(m_r) + DIGIT));

  // MUL step: a_sh already holds a << (DIGIT*k); b_sh[DIGIT-1:0] is digit k.
  always_comb begin
    digit  = b_sh[DIGIT-1:0];
    pp_cl  = '0;
    for (int i = 0; i < DIGIT; i++) begin
      if (digit[i]) pp_cl = pp_cl ^ (a_sh << i);
    end
    pp_int  = a_sh * {{(2*W-DIGIT){1'b0}}, digit};
    // Only modes 00, 01 and 10 run MUL, so mode bit 0 alone selects integer.
    mul_acc = mode_r[0] ? (acc + pp_int) : (acc ^ pp_cl);
  end

  // RED step: up to DIGIT positions chained within one cycle, never below m.
  always_comb begin
    poly_ext = {{(W-1){1'b0}}, poly_r};
    red_acc  = acc;
    red_j    = 0;
    for (int k = 0; k < DIGIT; k++) begin
      red_j = int'(jpos) - k;
      if ((red_j >= int'(m_r)) && (((red_acc >> red_j) & ONE_2W) != '0)) begin
        red_acc = red_acc ^ (poly_ext << (red_j - int'(m_r)));
      end
    end
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (in_valid) begin
          if (illegal_in)          state_nxt = S_DONE;
          else if (mode == 2'b11)  state_nxt = S_RED;
          else                     state_nxt = S_MUL;
        end
      end
      S_MUL:  if (mul_last)  state_nxt = (mode_r == 2'b10) ? S_RED : S_DONE;
      S_RED:  if (red_last)  state_nxt = S_DONE;
      S_DONE: if (out_ready) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Outputs
  always_comb begin
    in_ready  = (state == S_IDLE);
    busy      = (state != S_IDLE);
    out_valid = (state == S_DONE);
    err       = err_r;
    res       = mode_r[1] ? (acc & mask_2w(int'(m_r))) : acc;
  end

  // Accumulator and control registers; acc is reset so that res reads 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc    <= '0;
      mode_r <= '0;
      m_r    <= '0;
      err_r  <= 1'b0;
      cnt    <= '0;
      jpos   <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (in_valid) begin
            mode_r <= mode;
            m_r    <= polyn_grade;
            err_r  <= illegal_in;
            cnt    <= '0;
            jpos   <= JW'(2 * int'(polyn_grade) - 1);
            if ((mode == 2'b11) && !illegal_in)
              acc <= reduc_in & mask_2w(2 * int'(polyn_grade));
            else
              acc <= '0;
          end
        end
        S_MUL: begin
          acc <= mul_acc;
          cnt <= cnt + 1'b1;
        end
        S_RED: begin
          acc  <= red_acc;
          jpos <= jpos - JW'(DIGIT);
        end
        default: ;
      endcase
    end
  end

  // Operand registers; they are always loaded before use, so no reset.
  always_ff @(posedge clk) begin
    if ((state == S_IDLE) && in_valid) begin
      a_sh   <= {{W{1'b0}}, (mode[1] ? (a & mask_w(int'(polyn_grade))) : a)};
      b_sh   <= mode[1] ? (b & mask_w(int'(polyn_grade))) : b;
      poly_r <= polyn_red_in & mask_p(int'(polyn_grade) + 1);
    end else if (state == S_MUL) begin
      a_sh <= a_sh << DIGIT;
      b_sh <= b_sh >> DIGIT;
    end
  end

endmodule
